// File: rtl/spi_master.sv
// SPI master: shifts out a command+payload frame MSB first and, for read commands,
// waits a fixed number of cycles and then shifts in one data word from MISO.
module spi_master #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_frame,
  input  logic               MISO,
  output logic               SS_n,
  output logic               MOSI,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid
);

  localparam int CNT_M1  = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
  localparam int CNT_MAX = (CNT_M1 > RD_WAIT) ? CNT_M1 : RD_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_W-1:0]   tx_shift;
  logic [DATA_W-1:0]    rx_shift;
  logic                 is_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    SS_n       = 1'b0;
    MOSI       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        SS_n = 1'b1;
        busy = 1'b0;
        if (start) state_next = SEND;
      end
      SEND: begin
        MOSI = tx_shift[FRAME_W-1];
        if (cnt == CNT_W'(FRAME_W - 1)) begin
          if (!is_read)          state_next = DONE;
          else if (RD_WAIT == 0) state_next = RECV;
          else                   state_next = WAIT;
        end
      end
      WAIT: if (cnt == CNT_W'(RD_WAIT - 1)) state_next = RECV;
      RECV: if (cnt == CNT_W'(DATA_W - 1)) state_next = DONE;
      DONE: begin
        SS_n       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        SS_n       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // The counter restarts on every state change, so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      is_read  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_next != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + 1'b1;
      if (state == IDLE && start) begin
        tx_shift <= tx_frame;
        is_read  <= (tx_frame[FRAME_W-1 -: 2] == 2'b11);
      end
      if (state == SEND) tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
      if (state == RECV) begin
        rx_shift <= {rx_shift[DATA_W-2:0], MISO};
        if (state_next == DONE) begin
          rx_data  <= {rx_shift[DATA_W-2:0], MISO};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
